// File: rtl/time_manager_pkg.sv
// Shared types and constants for the emulation-time sequencer.
package time_manager_pkg;

   localparam int DEF_TIME_WIDTH = 32;
   localparam int STEP_CNT_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } tm_state_t;

endpackage

// File: rtl/time_min_tree.sv
// N-input unsigned minimum as a binary heap-ordered tree; on ties the lower index wins.
module time_min_tree #(
   parameter int N = 2,
   parameter int W = 32
) (
   input  logic [N*W-1:0] vals_i,
   output logic [W-1:0]   min_o
);

   localparam int LG = (N > 1) ? $clog2(N) : 0;
   localparam int P  = 1 << LG;

   logic [P*W-1:0] padded;
   logic [W-1:0]   nd [1:2*P-1];

   // Leaves live at nd[P..2P-1]; unused leaves hold all-ones so they never win a strict compare.
   always_comb begin
      padded            = '1;
      padded[N*W-1:0]   = vals_i;
      for (int i = 0; i < P; i++) nd[P+i] = padded[i*W +: W];
      for (int i = P - 1; i >= 1; i--)
         nd[i] = (nd[2*i+1] < nd[2*i]) ? nd[2*i+1] : nd[2*i];
      min_o = nd[1];
   end

endmodule

// File: rtl/time_manager.sv
// Global emulation-time sequencer: reduces clock next-event times to the earliest one
// and commits it once per clk_sys cycle until the latched stop time is reached.
module time_manager
   import time_manager_pkg::*;
#(
   parameter int N_CLK      = 2,
   parameter int TIME_WIDTH = DEF_TIME_WIDTH
) (
   input  logic                        clk_sys,
   input  logic                        rst_n,
   input  logic                        start,
   input  logic                        stall,
   input  logic [TIME_WIDTH-1:0]       time_stop,
   input  logic [N_CLK*TIME_WIDTH-1:0] time_clocks,
   output logic [TIME_WIDTH-1:0]       time_next,
   output logic                        time_valid,
   output logic [TIME_WIDTH-1:0]       time_curr,
   output logic [STEP_CNT_WIDTH-1:0]   step_count,
   output logic                        busy,
   output logic                        done
);

   tm_state_t                 state_q, state_d;
   logic [TIME_WIDTH-1:0]     stop_q, stop_d;
   logic [TIME_WIDTH-1:0]     curr_q, curr_d;
   logic [STEP_CNT_WIDTH-1:0] step_q, step_d;
   logic                      busy_q, done_q;
   logic                      err_q, err_d;

   time_min_tree #(.N(N_CLK), .W(TIME_WIDTH)) u_min (
      .vals_i (time_clocks),
      .min_o  (time_next)
   );

   always_comb begin
      state_d    = state_q;
      stop_d     = stop_q;
      curr_d     = curr_q;
      step_d     = step_q;
      time_valid = 1'b0;
      case (state_q)
         IDLE: if (start) begin
            state_d = RUN;
            stop_d  = time_stop;
            step_d  = '0;
         end
         RUN: if (!stall) begin
            if (time_next < stop_q) begin
               time_valid = 1'b1;
               curr_d     = time_next;
               if (step_q != '1) step_d = step_q + STEP_CNT_WIDTH'(1);
            end else begin
               state_d = DONE;
               curr_d  = stop_q;
            end
         end
         DONE: if (!start) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // A clock reporting an event behind committed time means the feedback loop broke.
      err_d = err_q | ((state_q == RUN) && (time_next < curr_q));
   end

   always_ff @(posedge clk_sys or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         stop_q  <= '0;
         curr_q  <= '0;
         step_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         stop_q  <= stop_d;
         curr_q  <= curr_d;
         step_q  <= step_d;
         busy_q  <= (state_d == RUN);
         done_q  <= (state_d == DONE);
         err_q   <= err_d;
      end
   end

   assign time_curr  = curr_q;
   assign step_count = step_q;
   assign busy       = busy_q;
   assign done       = done_q;

   a_monotonic: assert property (@(posedge clk_sys) disable iff (!rst_n) !err_d)
      else $error("time_manager: time_next went behind time_curr");

endmodule
